instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have port: clock  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port: start  in  1  begin execution from the current pc; sampled only in IDLE or HALTED.
REQ-004 SHALL have port: mem_addr  out  5  program memory word address.
REQ-005 SHALL have port: mem_rd  out  1  read strobe; mem_data is valid the cycle after mem_rd=1.
REQ-006 SHALL have port: mem_data  in  16  program word; instruction in [8:0] as III XXX YYY.
REQ-007 SHALL have port: ir  out  9  instruction to processor; held stable from ISSUE through the done cycle.
REQ-008 SHALL have port: din  out  16  immediate operand to processor; held stable until the next mvi load.
REQ-009 SHALL have port: run  out  1  one-cycle start pulse to processor.
REQ-010 SHALL have port: done  in  1  processor completion pulse.
REQ-011 SHALL have ports: busy  out  1  (state not IDLE/HALTED/ERROR); halted  out  1  (state HALTED); pc  out  5  (address of the current instruction).
REQ-012 SHALL have port: error  out  1  watchdog expiry flag (see Configuration).

Function
REQ-013 SHALL implement states IDLE, FETCH, DECODE, FETCH_IMM, LOAD_IMM, ISSUE, WAIT_DONE, HALTED, ERROR.
REQ-014 IDLE/HALTED: start=1 -> FETCH; otherwise hold.
REQ-015 FETCH: mem_rd=1, mem_addr=pc -> DECODE.
REQ-016 DECODE: latch mem_data[8:0] into ir; III=111 -> HALTED (processor not run); III=001 (mvi) -> FETCH_IMM; else -> ISSUE.
REQ-017 FETCH_IMM: mem_rd=1, mem_addr=pc+1 mod 32 -> LOAD_IMM; LOAD_IMM: latch mem_data into din -> ISSUE.
REQ-018 ISSUE: run=1 for exactly one cycle -> WAIT_DONE; run=0 in every other state.
REQ-019 WAIT_DONE: done=1 -> pc advances by 1 (2 for mvi), modulo 32, -> FETCH; done=0 -> hold.
REQ-020 done SHALL be ignored outside WAIT_DONE; done in the ISSUE cycle SHALL NOT count.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 pc wrap: 31+1=0, 31+2=1, 30+2=0; mvi at address 31 SHALL take its immediate from address 0.
REQ-023 mem_rd SHALL be 1 only in FETCH and FETCH_IMM; mem_addr SHALL be pc in all other states.
REQ-024 Non-mvi instruction latency: run asserted 2 cycles after FETCH entry; mvi: 4 cycles.
REQ-025 HALTED: pc SHALL remain at the HALT word address; start re-fetches that word and halts again.

Reset
REQ-026 reset=1 SHALL asynchronously force state IDLE, pc=0, ir=0, din=0, run=0, mem_rd=0, mem_addr=0, busy=0, halted=0, error=0, watchdog counter=0.
REQ-027 reset during any state, including WAIT_DONE, SHALL abort the instruction with no further run pulse; a done arriving after reset release SHALL be ignored.

Configuration
REQ-028 Macro SEQ_WATCHDOG_EN defined: 4-bit counter clears on ISSUE, increments each WAIT_DONE cycle; 16 WAIT_DONE cycles without done -> ERROR, error=1, busy=0; ERROR left only by reset; done in the 16th cycle still wins.
REQ-029 SEQ_WATCHDOG_EN undefined: no counter, WAIT_DONE waits indefinitely, ERROR unreachable, error tied 0.

Verification
REQ-030 Memory {0:0x0040, 1:0x0005, 2:0x01C0}, start pulse -> ir=0x040, din=0x0005, one run pulse; done -> pc=2; then halted=1, pc=2, no second run.
REQ-031 Word 0=0x0088 (add r1,r0), done returned 3 cycles after run -> ir=0x088 stable through done, pc=1 the cycle after done, mem_rd=1 with mem_addr=1.
REQ-032 pc=31 holding 0x0040, address 0 holding 0x1234 -> din=0x1234, pc=1 after done.
REQ-033 reset asserted in WAIT_DONE -> same-cycle pc=0, ir=0, run=0, busy=0; later done pulse -> no state change.
REQ-034 start pulse while busy and spurious done in FETCH -> no effect on pc, ir, or run count.
REQ-035 SEQ_WATCHDOG_EN defined, done never returned -> error=1 after 16 WAIT_DONE cycles, busy=0; undefined -> busy stays 1, error=0.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches III XXX YYY words (plus mvi immediates) from program memory,
// hands them to the processor with a one-cycle run pulse and waits for done. Optional macro: SEQ_WATCHDOG_EN.
module instr_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_data,
  output logic [8:0]  ir,
  output logic [15:0] din,
  output logic        run,
  input  logic        done,
  output logic        busy,
  output logic        halted,
  output logic [4:0]  pc,
  output logic        error
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_FETCH_IMM, S_LOAD_IMM,
    S_ISSUE, S_WAIT_DONE, S_HALTED, S_ERROR
  } state_t;

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t      state_q, state_d;
  logic [4:0]  pc_q, pc_d;
  logic [8:0]  ir_q, ir_d;
  logic [15:0] din_q, din_d;
  logic [4:0]  mem_addr_q, mem_addr_d;
  logic        mem_rd_q, mem_rd_d;
  logic        run_q, run_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;
`ifdef SEQ_WATCHDOG_EN
  logic [3:0]  wd_q, wd_d;
  logic        error_q, error_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    din_d   = din_q;
`ifdef SEQ_WATCHDOG_EN
    wd_d    = wd_q;
`endif
    case (state_q)
      S_IDLE, S_HALTED: if (start) state_d = S_FETCH;
      S_FETCH:          state_d = S_DECODE;
      S_DECODE: begin
        ir_d = mem_data[8:0];
        if (mem_data[8:6] == OP_HALT)     state_d = S_HALTED;
        else if (mem_data[8:6] == OP_MVI) state_d = S_FETCH_IMM;
        else                              state_d = S_ISSUE;
      end
      S_FETCH_IMM:      state_d = S_LOAD_IMM;
      S_LOAD_IMM: begin
        din_d   = mem_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
`ifdef SEQ_WATCHDOG_EN
        wd_d    = 4'd0;
`endif
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // done on the 16th waiting cycle still beats the watchdog
        if (done) begin
          pc_d    = pc_q + ((ir_q[8:6] == OP_MVI) ? 5'd2 : 5'd1);
          state_d = S_FETCH;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (wd_q == 4'hF) state_d = S_ERROR;
        else                   wd_d    = wd_q + 4'd1;
`endif
      end
      S_ERROR:          state_d = S_ERROR;
      default:          state_d = S_IDLE;
    endcase

    // outputs are registered, so derive them from the next state
    mem_rd_d   = (state_d == S_FETCH) || (state_d == S_FETCH_IMM);
    mem_addr_d = (state_d == S_FETCH_IMM) ? pc_d + 5'd1 : pc_d;
    run_d      = (state_d == S_ISSUE);
    busy_d     = !((state_d == S_IDLE) || (state_d == S_HALTED) || (state_d == S_ERROR));
    halted_d   = (state_d == S_HALTED);
`ifdef SEQ_WATCHDOG_EN
    error_d    = (state_d == S_ERROR);
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      din_q      <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wd_q       <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      din_q      <= din_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
`ifdef SEQ_WATCHDOG_EN
      wd_q       <= wd_d;
      error_q    <= error_d;
`endif
    end
  end

  assign pc       = pc_q;
  assign ir       = ir_q;
  assign din      = din_q;
  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign run      = run_q;
  assign busy     = busy_q;
  assign halted   = halted_q;
`ifdef SEQ_WATCHDOG_EN
  assign error    = error_q;
`else
  assign error    = 1'b0;
`endif

endmodule
